mux_3to1: RTL and testbench
===========================

# mux_3to1

Three-input, select-driven multiplexer with a combinational output and a registered copy of that output. It is a leaf datapath primitive used where a consumer needs both the immediate selection and a clock-aligned version of it. Select is two single-bit lines (s1 MSB, s0 LSB). The registered path is cleared by an asynchronous active-low reset.

## Interface
- WIDTH, default 1: bit width of i0, i1, i2, o1 and o2.
- RESET_VAL, default all-zeros: value loaded into o2 while reset is asserted.

Ports:
- clk  input  1  clock; o2 updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- i0  input  WIDTH  data input 0.
- i1  input  WIDTH  data input 1.
- i2  input  WIDTH  data input 2.
- s0  input  1  select LSB.
- s1  input  1  select MSB.
- o1  output  WIDTH  combinational mux output.
- o2  output  WIDTH  registered o1.

## Operation
- Select code {s1,s0}:
  - 00 selects i0.
  - 01 selects i1.
  - 10 selects i2.
  - 11 selects i2: s1=1 takes priority, and s0 is ignored.
- o1 equals the selected input at all times. It is purely combinational and does not depend on clk or rst_n.
- o2 captures o1 on every rising clk edge while rst_n=1.
- X/Z on a select bit propagates per the language semantics. No X-masking is required.
- No enable input: o2 reloads every cycle.

## Timing
- o1: zero-cycle latency. Changes in the same delta as any input or select change.
- o2: one-cycle latency. The value present on o1 just before rising edge N appears on o2 after edge N and holds until edge N+1.
- Input changes between edges are invisible to o2 unless they are still present at the next rising edge.
- Simultaneous input change and clock edge: o2 takes the pre-edge value of o1 (standard flop sampling). Sources must meet setup/hold relative to clk.
- Reset:
  - rst_n low forces o2=RESET_VAL immediately, without waiting for a clock edge, and holds it while low.
  - o1 is unaffected by reset.
- Reset release: the first capture occurs on the first rising edge with rst_n=1. Deassertion is synchronized externally.
- Reset mid-operation: o2 drops to RESET_VAL asynchronously. Captures resume on the first rising edge after release.

## Structure
- Shared package (mux_pkg):
  - 2-bit select encoding constants SEL_I0=2'b00, SEL_I1=2'b01, SEL_I2=2'b10, SEL_I2_ALT=2'b11.
  - A typedef for the select vector.
- Sub-module mux3_comb (parameterized WIDTH): produces o1 from i0/i1/i2 and {s1,s0}.
- Top level instantiates mux3_comb and adds the single async-reset register for o2.

## Test plan
- Reset: assert rst_n=0 with i0=1, s1s0=00 -> o2=0 immediately and through clock edges. o1=1 throughout.
- Select sweep: i0=1,i1=0,i2=1 (combinational check, between edges).
  - s1s0=00 -> o1=1.
  - s1s0=01 -> o1=0.
  - s1s0=10 -> o1=1.
  - s1s0=11 -> o1=1.
- Code-11 priority: i0=0,i1=1,i2=1 then i0=1,i1=1,i2=0, both with s1s0=11 -> o1=1, then o1=0. The result tracks i2 only.
- Registered latency:
  - Apply i0=1,i1=0,i2=1,s1s0=01 between edges -> o1=0 at once.
  - o2 becomes 0 only after the next rising edge.
  - Change to s1s0=00 -> o1=1 at once, o2=1 one edge later.
- Mid-cycle glitch: toggle i2 with s1s0=10 for less than half a period, returning before the next edge -> o1 follows the toggle, o2 never shows it.
- Async reset mid-run: with o2=1, pull rst_n low between edges -> o2=0 without a clock edge. Release rst_n -> o2 reloads from o1 on the next rising edge.

Source files
------------

// File: rtl/mux_3to1_pkg.sv
// mux_pkg: shared definitions for the three-input multiplexer.
//
// Contents:
//   sel_t       - 2-bit select vector, bit 1 = s1 (MSB), bit 0 = s0 (LSB)
//   SEL_I0      - code selecting i0
//   SEL_I1      - code selecting i1
//   SEL_I2      - code selecting i2
//   SEL_I2_ALT  - second code selecting i2 (s1 dominates, s0 ignored)
//   make_sel()  - packs the two discrete select lines into a sel_t
package mux_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_I0     = 2'b00;
    localparam sel_t SEL_I1     = 2'b01;
    localparam sel_t SEL_I2     = 2'b10;
    localparam sel_t SEL_I2_ALT = 2'b11;

    function automatic sel_t make_sel(input logic s1, input logic s0);
        return {s1, s0};
    endfunction

endpackage

// File: rtl/mux_3to1_comb.sv
// mux3_comb: purely combinational 3:1 selector.
//
// Ports:
//   i0, i1, i2 [WIDTH-1:0]  data inputs
//   sel        [1:0]        select code {s1,s0}
//   o          [WIDTH-1:0]  selected input
module mux3_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  sel_t             sel,
    output logic [WIDTH-1:0] o
);

    always_comb begin
        o = i0;
        case (sel)
            SEL_I0:             o = i0;
            SEL_I1:             o = i1;
            // s1 high always picks i2, whatever s0 is.
            SEL_I2, SEL_I2_ALT: o = i2;
            default:            o = i0;
        endcase
    end

endmodule

// File: rtl/mux_3to1.sv
// mux_3to1: 3:1 multiplexer with a combinational output and a registered copy.
//
// Ports:
//   clk    clock, o2 updates on the rising edge
//   rst_n  asynchronous active-low reset, forces o2 to RESET_VAL
//   i0..i2 [WIDTH-1:0] data inputs
//   s0, s1 select LSB / MSB
//   o1     [WIDTH-1:0] combinational selection (unaffected by reset)
//   o2     [WIDTH-1:0] o1 registered once per clock
module mux_3to1
    import mux_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2
);

    sel_t             sel;
    logic [WIDTH-1:0] o2_d;
    logic [WIDTH-1:0] o2_q;

    assign sel = make_sel(s1, s0);

    mux3_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .i0  (i0),
        .i1  (i1),
        .i2  (i2),
        .sel (sel),
        .o   (o1)
    );

    // No enable: the register reloads from o1 every cycle.
    always_comb begin
        o2_d = o1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o2_q <= RESET_VAL;
        end else begin
            o2_q <= o2_d;
        end
    end

    assign o2 = o2_q;

endmodule

// File: tb/tb_mux_3to1.sv
module tb_mux_3to1;

    logic       clk;
    logic       rst_n;
    logic [0:0] i0, i1, i2;
    logic       s0, s1;
    logic [0:0] o1, o2;
    logic [7:0] a0, a1, a2;
    logic [7:0] w1, w2;

    int checks;
    int errors;

    // clock/reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    mux_3to1 u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i0    (i0),
        .i1    (i1),
        .i2    (i2),
        .s0    (s0),
        .s1    (s1),
        .o1    (o1),
        .o2    (o2)
    );

    mux_3to1 #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5)
    ) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .i0    (a0),
        .i1    (a1),
        .i2    (a2),
        .s0    (s0),
        .s1    (s1),
        .o1    (w1),
        .o2    (w2)
    );

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1; i0 = 1'b1; i1 = 1'b0; i2 = 1'b0; s1 = 1'b0; s0 = 1'b0;
        a0 = 8'h11; a1 = 8'h22; a2 = 8'h33;
        @(posedge clk); #1;
        checks++;
        if (o2 !== 1'b1) begin errors++; $display("FAIL reset_pre_o2 got %b exp 1", o2); end
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o2 !== 1'b0) begin errors++; $display("FAIL reset_async_o2 got %b exp 0", o2); end
        checks++;
        if (w2 !== 8'hA5) begin errors++; $display("FAIL reset_val_w2 got %h exp a5", w2); end
        checks++;
        if (o1 !== 1'b1) begin errors++; $display("FAIL reset_o1 got %b exp 1", o1); end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if (o2 !== 1'b0) begin errors++; $display("FAIL reset_hold_o2 cyc %0d got %b exp 0", k, o2); end
            checks++;
            if (o1 !== 1'b1) begin errors++; $display("FAIL reset_hold_o1 cyc %0d got %b exp 1", k, o1); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (o2 !== 1'b0) begin errors++; $display("FAIL reset_release_early got %b exp 0", o2); end
        @(posedge clk); #1;
        checks++;
        if (o2 !== 1'b1) begin errors++; $display("FAIL reset_first_capture got %b exp 1", o2); end
        checks++;
        if (w2 !== 8'h11) begin errors++; $display("FAIL reset_first_capture_w2 got %h exp 11", w2); end
    endtask

    task automatic test_select_sweep();
        logic [1:0] codes [4];
        logic       exp1  [4];
        logic [7:0] exp8  [4];
        codes[0] = 2'b00; exp1[0] = 1'b1; exp8[0] = 8'h11;
        codes[1] = 2'b01; exp1[1] = 1'b0; exp8[1] = 8'h22;
        codes[2] = 2'b10; exp1[2] = 1'b1; exp8[2] = 8'h33;
        codes[3] = 2'b11; exp1[3] = 1'b1; exp8[3] = 8'h33;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i0 = 1'b1; i1 = 1'b0; i2 = 1'b1;
            a0 = 8'h11; a1 = 8'h22; a2 = 8'h33;
            {s1, s0} = codes[k];
            #1;
            checks++;
            if (o1 !== exp1[k]) begin errors++; $display("FAIL sweep_o1 sel %b got %b exp %b", codes[k], o1, exp1[k]); end
            checks++;
            if (w1 !== exp8[k]) begin errors++; $display("FAIL sweep_w1 sel %b got %h exp %h", codes[k], w1, exp8[k]); end
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        {s1, s0} = 2'b11; i0 = 1'b0; i1 = 1'b1; i2 = 1'b1;
        #1;
        checks++;
        if (o1 !== 1'b1) begin errors++; $display("FAIL prio_a got %b exp 1", o1); end
        #1;
        i0 = 1'b1; i1 = 1'b1; i2 = 1'b0;
        #1;
        checks++;
        if (o1 !== 1'b0) begin errors++; $display("FAIL prio_b got %b exp 0", o1); end
    endtask

    task automatic test_latency();
        @(negedge clk);
        i0 = 1'b1; i1 = 1'b0; i2 = 1'b1; {s1, s0} = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        {s1, s0} = 2'b01;
        #1;
        checks++;
        if (o1 !== 1'b0) begin errors++; $display("FAIL lat_o1_now got %b exp 0", o1); end
        checks++;
        if (o2 !== 1'b1) begin errors++; $display("FAIL lat_o2_before got %b exp 1", o2); end
        @(posedge clk); #1;
        checks++;
        if (o2 !== 1'b0) begin errors++; $display("FAIL lat_o2_after got %b exp 0", o2); end
        @(negedge clk);
        {s1, s0} = 2'b00;
        #1;
        checks++;
        if (o1 !== 1'b1) begin errors++; $display("FAIL lat2_o1_now got %b exp 1", o1); end
        checks++;
        if (o2 !== 1'b0) begin errors++; $display("FAIL lat2_o2_before got %b exp 0", o2); end
        @(posedge clk); #1;
        checks++;
        if (o2 !== 1'b1) begin errors++; $display("FAIL lat2_o2_after got %b exp 1", o2); end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        {s1, s0} = 2'b10; i2 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (o2 !== 1'b0) begin errors++; $display("FAIL glitch_setup got %b exp 0", o2); end
        @(negedge clk);
        #1 i2 = 1'b1;
        #1;
        checks++;
        if (o1 !== 1'b1) begin errors++; $display("FAIL glitch_o1_high got %b exp 1", o1); end
        #1 i2 = 1'b0;
        #1;
        checks++;
        if (o1 !== 1'b0) begin errors++; $display("FAIL glitch_o1_low got %b exp 0", o1); end
        @(posedge clk); #1;
        checks++;
        if (o2 !== 1'b0) begin errors++; $display("FAIL glitch_o2 got %b exp 0", o2); end
    endtask

    task automatic test_async_mid();
        @(negedge clk);
        {s1, s0} = 2'b00; i0 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (o2 !== 1'b1) begin errors++; $display("FAIL mid_setup got %b exp 1", o2); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (o2 !== 1'b0) begin errors++; $display("FAIL mid_async_o2 got %b exp 0", o2); end
        checks++;
        if (o1 !== 1'b1) begin errors++; $display("FAIL mid_o1 got %b exp 1", o1); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (o2 !== 1'b0) begin errors++; $display("FAIL mid_release_early got %b exp 0", o2); end
        @(posedge clk); #1;
        checks++;
        if (o2 !== 1'b1) begin errors++; $display("FAIL mid_reload got %b exp 1", o2); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b1;
        i0 = 1'b0; i1 = 1'b0; i2 = 1'b0; s0 = 1'b0; s1 = 1'b0;
        a0 = 8'h00; a1 = 8'h00; a2 = 8'h00;
        test_reset();
        test_select_sweep();
        test_priority();
        test_latency();
        test_glitch();
        test_async_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
